// File: rtl/clk_div_prog.sv
// Multi-channel programmable clock divider with shadowed, glitch-free divisor updates.
// Optional phase-align strobe `sync` when CLK_DIV_SYNC_EN is defined.
module clk_div_prog #(
    parameter  int CH      = 2,
    parameter  int DIV_W   = 26,
    parameter  int DEF_DIV = 33333333,
    localparam int SEL_W   = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic             clk_100MHz,
    input  logic             rst,
    input  logic [CH-1:0]    en,
    input  logic             div_load,
    input  logic [SEL_W-1:0] div_sel,
    input  logic [DIV_W-1:0] div_val,
`ifdef CLK_DIV_SYNC_EN
    input  logic             sync,
`endif
    output logic             div_ack,
    output logic             div_err,
    output logic [CH-1:0]    clk_out,
    output logic [CH-1:0]    tick
);

    localparam logic [DIV_W-1:0] DEF_V = DIV_W'(DEF_DIV);
    localparam logic [DIV_W-1:0] ONE_V = DIV_W'(1);
    localparam logic [DIV_W-1:0] TWO_V = DIV_W'(2);

    logic [DIV_W-1:0] act_q [CH];
    logic [DIV_W-1:0] act_d [CH];
    logic [DIV_W-1:0] shd_q [CH];
    logic [DIV_W-1:0] shd_d [CH];
    logic [DIV_W-1:0] cnt_q [CH];
    logic [DIV_W-1:0] cnt_d [CH];
    logic [CH-1:0]    pend_q, pend_d;
    logic [CH-1:0]    clk_q, clk_d;
    logic [CH-1:0]    tick_q, tick_d;
    logic             ack_q, ack_d;
    logic             err_q, err_d;
    logic [CH-1:0]    wrap;
    logic             sel_ok;
    logic             ld_ok;
    logic             sync_now;

`ifdef CLK_DIV_SYNC_EN
    assign sync_now = sync;
`else
    assign sync_now = 1'b0;
`endif

    always_comb begin
        sel_ok = (int'(div_sel) < CH);
        ld_ok  = div_load && (div_val >= TWO_V) && sel_ok;
        ack_d  = ld_ok;
        err_d  = div_load && !ld_ok;
        pend_d = pend_q;
        clk_d  = '0;
        tick_d = '0;
        wrap   = '0;
        for (int i = 0; i < CH; i++) begin
            act_d[i] = act_q[i];
            shd_d[i] = shd_q[i];
            cnt_d[i] = cnt_q[i];
            // >= rather than == keeps the counter bounded even if A ever shrank below C
            wrap[i]  = (cnt_q[i] >= (act_q[i] - ONE_V));
            if (sync_now || !en[i]) begin
                cnt_d[i] = '0;
                if (pend_q[i]) begin
                    act_d[i]  = shd_q[i];
                    pend_d[i] = 1'b0;
                end
            end else begin
                clk_d[i]  = (cnt_q[i] >= (act_q[i] >> 1));
                tick_d[i] = wrap[i];
                if (wrap[i]) begin
                    cnt_d[i] = '0;
                    if (pend_q[i]) begin
                        act_d[i]  = shd_q[i];
                        pend_d[i] = 1'b0;
                    end
                end else begin
                    cnt_d[i] = cnt_q[i] + ONE_V;
                end
            end
            // A new load lands after the wrap/sync decision, so it waits for the next boundary
            if (ld_ok && (int'(div_sel) == i)) begin
                shd_d[i]  = div_val;
                pend_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_100MHz) begin
        if (rst) begin
            for (int i = 0; i < CH; i++) begin
                act_q[i] <= DEF_V;
                shd_q[i] <= DEF_V;
                cnt_q[i] <= '0;
            end
            pend_q <= '0;
            clk_q  <= '0;
            tick_q <= '0;
            ack_q  <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            for (int i = 0; i < CH; i++) begin
                act_q[i] <= act_d[i];
                shd_q[i] <= shd_d[i];
                cnt_q[i] <= cnt_d[i];
            end
            pend_q <= pend_d;
            clk_q  <= clk_d;
            tick_q <= tick_d;
            ack_q  <= ack_d;
            err_q  <= err_d;
        end
    end

    assign clk_out = clk_q;
    assign tick    = tick_q;
    assign div_ack = ack_q;
    assign div_err = err_q;

endmodule

// File: doc/clk_div_prog.md
CLK_DIV_PROG -- requirements
Module: clk_div_prog

Interface
REQ-001 Parameter CH, default 2, number of independent divider channels (1..8).
REQ-002 Parameter DIV_W, default 26, divisor and counter width in bits.
REQ-003 Parameter DEF_DIV, default 33333333, per-channel divisor loaded at reset (3 Hz at 100 MHz).
REQ-004 clk_100MHz  input  1  system clock; all logic on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 en  input  CH  per-channel run enable.
REQ-007 div_load  input  1  single-cycle request to program a divisor.
REQ-008 div_sel  input  clog2(CH) (min 1)  target channel for div_load.
REQ-009 div_val  input  DIV_W  requested divisor N.
REQ-010 div_ack  output  1  one-cycle pulse, request accepted.
REQ-011 div_err  output  1  one-cycle pulse, request rejected.
REQ-012 clk_out  output  CH  per-channel divided clock, registered.
REQ-013 tick  output  CH  per-channel one-cycle pulse per output period, registered.
REQ-014 sync  input  1  phase-align strobe; present only when CLK_DIV_SYNC_EN is defined.

Function
REQ-015 Each channel holds an active divisor A, a shadow divisor S, a pending flag P, and a DIV_W-bit counter C.
REQ-016 Enabled channel: C increments each cycle from 0 to A-1, then wraps to 0.
REQ-017 clk_out[i] next value: 1 when en[i] and C >= floor(A/2), else 0 (one-cycle latency from C).
REQ-018 Duty cycle: exact 50% for even A; for odd A, high for ceil(A/2) cycles.
REQ-019 tick[i] next value: 1 when en[i] and C == A-1, else 0, so tick coincides with C == 0 after wrap.
REQ-020 Disabled channel (en[i]=0): C held at 0; clk_out[i] and tick[i] forced 0 from the next cycle.
REQ-021 Re-enable: C starts counting from 0 in the cycle after en[i] rises.
REQ-022 Accepted load (div_load=1, div_val >= 2, div_sel < CH): S <= div_val, P <= 1; div_ack=1 in the next cycle.
REQ-023 Rejected load (div_val < 2 or div_sel >= CH): no state change; div_err=1 in the next cycle.
REQ-024 div_ack and div_err are never both high; both 0 when no load is presented.
REQ-025 Glitch-free change: on the wrap cycle (C == A-1 with P=1), A <= S, P <= 0; the old period always completes.
REQ-026 Load in the same cycle as a wrap: the wrap uses the prior S and P; the new value waits for the next wrap.
REQ-027 Back-to-back loads to one channel before a wrap: the last accepted value wins.
REQ-028 Pending load while en[i]=0: A <= S applied in the next cycle.
REQ-029 Divisor width: DIV_W bits, unsigned; the counter never exceeds A-1.

Reset
REQ-030 With rst=1 at a clock edge, every channel: A=DEF_DIV, S=DEF_DIV, P=0, C=0.
REQ-031 With rst=1 at a clock edge, all outputs are 0: clk_out, tick, div_ack, div_err.
REQ-032 Reset mid-period or with a load pending discards the pending divisor; counting resumes from 0 on the first cycle after rst drops, if enabled.
REQ-033 Reset takes priority over div_load, en and sync in the same cycle.

Configuration
REQ-034 With CLK_DIV_SYNC_EN defined, port sync exists. sync=1 sets C=0 on every channel in the next cycle, applies any pending S to A, and clears P.
REQ-035 The cycle following a sync produces no tick.
REQ-036 A div_load coinciding with sync is captured into S and stays pending.
REQ-037 Without CLK_DIV_SYNC_EN, the sync port and all sync logic are absent; behaviour is per REQ-015..REQ-029 only.

Verification
REQ-038 Reset, CH=2, en=2'b11, both divisors set to 4 -> clk_out[0] = 0,0,1,1 repeating, period 4; tick every 4th cycle aligned with C=0.
REQ-039 A=5 -> clk_out high 3 cycles, low 2; tick period 5.
REQ-040 Load 6 to ch0 at C=1 of a period with A=4 -> div_ack next cycle; the current 4-cycle period completes, then period is 6. Repeat the load on the wrap cycle -> applied one period later.
REQ-041 Load div_val=1, and separately div_sel=3 with CH=2 -> div_err pulse, no ack, divisors unchanged.
REQ-042 en[1] dropped mid-period -> clk_out[1]=0 and tick[1]=0 next cycle. Load 8 while disabled, then re-enable -> first tick after 8 cycles.
REQ-043 With CLK_DIV_SYNC_EN: channels at different phases with A=4 and 6, pulse sync -> both C=0 the next cycle, no tick that cycle, and coincident ticks every 12 cycles thereafter.
